uart_rx_fifo: RTL and testbench

Receive-side peer for the MCU UART link. Oversamples a 115200-baud 8N1 serial line, validates start and stop bits, and buffers received bytes in a small show-ahead FIFO. Drives an active-low clear-to-send line back to the transmitting UART to pause it before the FIFO overflows. Sits at the host/test-harness end of the MCU UART's tx/clear_to_send pair, or in front of any on-chip consumer of serial bytes.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_byte_fifo.sv | 60 ++++++
 rtl/uart_rx_fifo.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Holds the receiver FSM state encoding and the 115200-baud frame constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int UART_CLKS_PER_BIT_115200 = 434;
  localparam int UART_FRAME_DATA_BITS     = 8;

endpackage

// File: rtl/uart_byte_fifo.sv
// Show-ahead byte FIFO: head is combinational from the read pointer, so a pop shows the next byte the following cycle.
// Push when full is dropped unless a pop happens in the same cycle; pop when empty is ignored.
module uart_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [7:0]              push_data,
  input  logic                    pop,
  output logic [7:0]              head,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign empty  = (r_count == '0);
  assign full   = (r_count == (AW+1)'(DEPTH));
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);
  assign count  = r_count;
  // Head reads zero while empty so the output is defined straight out of reset.
  assign head   = empty ? 8'h00 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead byte FIFO; byte visible one cycle after the stop sample. cts_n asserts at FIFO_DEPTH-1 entries.
// Build with UART_RX_SYNC_EN to add a 2-flop input synchroniser (all sample points shift 2 cycles later).
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_115200,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx,
  output logic [7:0]                   rx_data,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         frame_error,
  output logic                         overrun,
  input  logic                         err_clear,
  output logic                         cts_n
);

  localparam int DW = UART_FRAME_DATA_BITS;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DW);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DW - 1);

  rx_state_t     r_state;
  rx_state_t     w_state_next;
  logic [BW-1:0] r_baud_cnt;
  logic [IW-1:0] r_bit_idx;
  logic [DW-1:0] r_shift;
  logic          r_rx_prev;
  logic          r_frame_error;
  logic          r_overrun;
  logic          r_cts_n;
  logic          w_rx_s;
  logic          w_tick;
  logic          w_shift_en;
  logic          w_push;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_fe_set;
  logic          w_ovr_set;
  logic [7:0]    w_head;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_next;
  logic          w_full;
  logic          w_empty;

`ifdef UART_RX_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx};
    end
  end

  assign w_rx_s = r_sync[1];
`else
  assign w_rx_s = rx;
`endif

  // START waits half a bit to land mid-bit; every later sample is a full bit apart.
  assign w_tick = (r_state == START) ? (r_baud_cnt == HALF_LAST)
                                     : (r_baud_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (r_rx_prev & ~w_rx_s) w_state_next = START;
      START:   if (w_tick) w_state_next = w_rx_s ? IDLE : DATA;
      DATA:    if (w_tick && r_bit_idx == IDX_LAST) w_state_next = STOP;
      STOP:    if (w_tick) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_shift_en = 1'b0;
    w_push     = 1'b0;
    w_ovr_set  = 1'b0;
    w_fe_set   = 1'b0;
    if (r_state == DATA) begin
      w_shift_en = w_tick;
    end
    if (r_state == STOP && w_tick) begin
      w_push    = w_rx_s & w_push_ok;
      w_ovr_set = w_rx_s & ~w_push_ok;
      w_fe_set  = ~w_rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_rx_prev  <= 1'b1;
    end else begin
      r_rx_prev <= w_rx_s;
      if (r_state == IDLE || w_tick) begin
        r_baud_cnt <= '0;
      end else begin
        r_baud_cnt <= r_baud_cnt + 1'b1;
      end
      if (r_state == IDLE) begin
        r_bit_idx <= '0;
      end else if (w_shift_en) begin
        r_bit_idx <= r_bit_idx + 1'b1;
        r_shift   <= {w_rx_s, r_shift[DW-1:1]};
      end
    end
  end

  assign w_pop     = ~w_empty & rx_ready;
  assign w_push_ok = ~w_full | w_pop;

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (r_shift),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_comb begin
    w_count_next = w_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = w_count + CW'(1);
      2'b01:   w_count_next = w_count - CW'(1);
      default: w_count_next = w_count;
    endcase
  end

  // Pause the peer one entry early so a byte already on the wire still fits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_error <= 1'b0;
      r_overrun     <= 1'b0;
      r_cts_n       <= 1'b1;
    end else begin
      r_cts_n <= (w_count_next >= CW'(FIFO_DEPTH - 1));
      if (err_clear) begin
        r_frame_error <= 1'b0;
        r_overrun     <= 1'b0;
      end else begin
        if (w_fe_set)  r_frame_error <= 1'b1;
        if (w_ovr_set) r_overrun     <= 1'b1;
      end
    end
  end

  assign rx_data     = w_head;
  assign rx_valid    = ~w_empty;
  assign fifo_count  = w_count;
  assign frame_error = r_frame_error;
  assign overrun     = r_overrun;
  assign cts_n       = r_cts_n;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 8 clk/bit and a 4-entry FIFO.
module tb_uart_rx_fifo;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [2:0] fifo_count;
  logic       frame_error;
  logic       overrun;
  logic       err_clear;
  logic       cts_n;

  int n_pass  = 0;
  int n_total = 0;

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .fifo_count  (fifo_count),
    .frame_error (frame_error),
    .overrun     (overrun),
    .err_clear   (err_clear),
    .cts_n       (cts_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All stimulus changes and checks happen 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int idle);
    rx = 1'b1;
    step(idle);
    rx = 1'b0;
    step(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(CPB);
    end
    rx = stop_bit;
    step(CPB);
    rx = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; rx = 1'b1; rx_ready = 1'b0; err_clear = 1'b0;
    step(3);
    n_total++;
    if ({rx_valid, fifo_count, frame_error, overrun, cts_n, rx_data} !== {1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00})
      $display("FAIL reset_state got valid=%b cnt=%0d fe=%b ovr=%b cts_n=%b data=%h want 0 0 0 0 1 00",
               rx_valid, fifo_count, frame_error, overrun, cts_n, rx_data);
    else n_pass++;
    rst = 1'b0;
    step(1);
    n_total++;
    if (cts_n !== 1'b0) $display("FAIL reset_cts_release got %b want 0", cts_n);
    else n_pass++;
  endtask

  task automatic test_single;
    send_frame(8'hA5, 1'b1, 4);
    n_total++;
    if ({rx_valid, rx_data, fifo_count} !== {1'b1, 8'hA5, 3'd1})
      $display("FAIL single_frame got valid=%b data=%h cnt=%0d want 1 a5 1", rx_valid, rx_data, fifo_count);
    else n_pass++;
    n_total++;
    if ({frame_error, overrun, cts_n} !== 3'b000)
      $display("FAIL single_flags got fe=%b ovr=%b cts_n=%b want 000", frame_error, overrun, cts_n);
    else n_pass++;
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    n_total++;
    if ({rx_valid, fifo_count} !== {1'b0, 3'd0})
      $display("FAIL single_pop got valid=%b cnt=%0d want 0 0", rx_valid, fifo_count);
    else n_pass++;
  endtask

  task automatic test_false_start;
    rx = 1'b0;
    step(3);
    rx = 1'b1;
    step(2 * CPB);
    n_total++;
    if ({rx_valid, fifo_count, frame_error} !== {1'b0, 3'd0, 1'b0})
      $display("FAIL false_start got valid=%b cnt=%0d fe=%b want 0 0 0", rx_valid, fifo_count, frame_error);
    else n_pass++;
    send_frame(8'h3C, 1'b1, 2);
    n_total++;
    if ({rx_valid, rx_data, fifo_count} !== {1'b1, 8'h3C, 3'd1})
      $display("FAIL after_false_start got valid=%b data=%h cnt=%0d want 1 3c 1", rx_valid, rx_data, fifo_count);
    else n_pass++;
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
  endtask

  task automatic test_frame_error;
    send_frame(8'h55, 1'b0, 2);
    step(4);
    n_total++;
    if ({frame_error, fifo_count, rx_valid, overrun} !== {1'b1, 3'd0, 1'b0, 1'b0})
      $display("FAIL frame_error_set got fe=%b cnt=%0d valid=%b ovr=%b want 1 0 0 0",
               frame_error, fifo_count, rx_valid, overrun);
    else n_pass++;
    err_clear = 1'b1;
    step(1);
    err_clear = 1'b0;
    n_total++;
    if (frame_error !== 1'b0) $display("FAIL frame_error_clear got %b want 0", frame_error);
    else n_pass++;
  endtask

  task automatic test_fill_cts;
    send_frame(8'h01, 1'b1, 2);
    n_total++;
    if ({fifo_count, cts_n} !== {3'd1, 1'b0}) $display("FAIL cts_after_1 got cnt=%0d cts_n=%b want 1 0", fifo_count, cts_n);
    else n_pass++;
    send_frame(8'h02, 1'b1, 2);
    n_total++;
    if ({fifo_count, cts_n} !== {3'd2, 1'b0}) $display("FAIL cts_after_2 got cnt=%0d cts_n=%b want 2 0", fifo_count, cts_n);
    else n_pass++;
    send_frame(8'h03, 1'b1, 2);
    n_total++;
    if ({fifo_count, cts_n} !== {3'd3, 1'b1}) $display("FAIL cts_after_3 got cnt=%0d cts_n=%b want 3 1", fifo_count, cts_n);
    else n_pass++;
  endtask

  task automatic test_overrun_drain;
    logic [7:0] exp_b;
    send_frame(8'h04, 1'b1, 2);
    n_total++;
    if ({fifo_count, overrun, cts_n} !== {3'd4, 1'b0, 1'b1})
      $display("FAIL full_count got cnt=%0d ovr=%b cts_n=%b want 4 0 1", fifo_count, overrun, cts_n);
    else n_pass++;
    send_frame(8'h05, 1'b1, 2);
    n_total++;
    if ({overrun, fifo_count, rx_data, frame_error} !== {1'b1, 3'd4, 8'h01, 1'b0})
      $display("FAIL overrun_set got ovr=%b cnt=%0d head=%h fe=%b want 1 4 01 0", overrun, fifo_count, rx_data, frame_error);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      exp_b = 8'(i + 1);
      n_total++;
      if ({rx_valid, rx_data} !== {1'b1, exp_b})
        $display("FAIL drain_%0d got valid=%b data=%h want 1 %h", i, rx_valid, rx_data, exp_b);
      else n_pass++;
      rx_ready = 1'b1;
      step(1);
      rx_ready = 1'b0;
    end
    n_total++;
    if ({rx_valid, fifo_count, cts_n} !== {1'b0, 3'd0, 1'b0})
      $display("FAIL drained got valid=%b cnt=%0d cts_n=%b want 0 0 0", rx_valid, fifo_count, cts_n);
    else n_pass++;
    err_clear = 1'b1;
    step(1);
    err_clear = 1'b0;
    n_total++;
    if (overrun !== 1'b0) $display("FAIL overrun_clear got %b want 0", overrun);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    send_frame(8'hAA, 1'b1, 2);
    send_frame(8'h0F, 1'b1, 0);
    n_total++;
    if ({fifo_count, rx_data} !== {3'd2, 8'hAA})
      $display("FAIL b2b_first got cnt=%0d data=%h want 2 aa", fifo_count, rx_data);
    else n_pass++;
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    n_total++;
    if ({rx_valid, rx_data, fifo_count} !== {1'b1, 8'h0F, 3'd1})
      $display("FAIL b2b_second got valid=%b data=%h cnt=%0d want 1 0f 1", rx_valid, rx_data, fifo_count);
    else n_pass++;
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    n_total++;
    if ({rx_valid, frame_error, overrun} !== 3'b000)
      $display("FAIL b2b_end got valid=%b fe=%b ovr=%b want 000", rx_valid, frame_error, overrun);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; rx_ready = 1'b0; err_clear = 1'b0;
    #1;
    test_reset;
    test_single;
    test_false_start;
    test_frame_error;
    test_fill_cts;
    test_overrun_drain;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
